// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Misses and all stores go to backing memory over a registered req/ack handshake.
module dcache_dm #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Read,
  input  logic              Write,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] input_data,
  output logic [DATA_W-1:0] output_buffer,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RFILL, WTHRU} state_t;

  state_t              state;
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES];

  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                hit;

  assign req_idx  = addr[INDEX_W-1:0];
  assign req_tag  = addr[ADDR_W-1:INDEX_W];
  // A refill lands on the line named by the address already held on the memory bus.
  assign fill_idx = mem_addr[INDEX_W-1:0];
  assign fill_tag = mem_addr[ADDR_W-1:INDEX_W];

  // A same-cycle flush invalidates the line before lookup, so it forces a miss.
  assign hit  = valid[req_idx] && !flush && (tag_mem[req_idx] == req_tag);
  assign busy = (state != IDLE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // NOTE: tag/data arrays have no reset; valid bits alone decide whether a line is usable,
  // and leaving the arrays unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == IDLE && Write && hit)
      data_mem[req_idx] <= input_data;
    if (state == RFILL && mem_ack) begin
      data_mem[fill_idx] <= mem_rdata;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  // NOTE: all state below uses non-blocking assignment so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= '0;
      output_buffer <= '0;
      done          <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush)
            valid <= '0;
          if (Write || Read) begin
            if (hit) hit_count  <= sat_inc(hit_count);
            else     miss_count <= sat_inc(miss_count);
          end
          if (Write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= input_data;
            state     <= WTHRU;
          end else if (Read) begin
            if (hit) begin
              output_buffer <= data_mem[req_idx];
              done          <= 1'b1;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= addr;
              state    <= RFILL;
            end
          end
        end
        RFILL: begin
          if (mem_ack) begin
            valid[fill_idx] <= 1'b1;
            output_buffer   <= mem_rdata;
            done            <= 1'b1;
            mem_req         <= 1'b0;
            state           <= IDLE;
          end
        end
        WTHRU: begin
          if (mem_ack) begin
            done    <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
